// File: rtl/lj_pair_feeder.sv
// lj_pair_feeder
//
// Streams (reference, neighbour) position pairs into the combinational LJ force unit.
// One reference particle is latched on start. The neighbour-cell position memory
// (synchronous BRAM, 1-cycle read latency) is then walked from address 0 to N-1.
// When the neighbour cell is the reference's own cell, the self-pair is skipped.
// Each pair leaves on a valid/ready handshake through a 2-entry buffer, so
// downstream backpressure never drops or duplicates a pair.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               pulse; begins a pass (accepted only when idle)
//   ref_pos, ref_idx    reference position / index within its cell (latched)
//   self_cell           neighbour cell is the reference's own cell (latched)
//   num_neighbors       neighbour count N, 0..2^ADDR_W (latched)
//   mem_rd_en, mem_addr neighbour-memory read strobe / address
//   mem_rd_data         read data, valid the cycle after mem_rd_en
//   reference           latched reference position
//   neighbor            neighbour position at the head of the buffer
//   neighbor_idx        memory index of that neighbour
//   pair_valid          head of buffer valid
//   pair_ready          downstream accepts; transfer = pair_valid & pair_ready
//   busy                pass in progress
//   done                1-cycle pulse at end of pass
module lj_pair_feeder #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned POS_W  = 96
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [POS_W-1:0]  ref_pos,
  input  logic [ADDR_W-1:0] ref_idx,
  input  logic              self_cell,
  input  logic [ADDR_W:0]   num_neighbors,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [POS_W-1:0]  mem_rd_data,
  output logic [POS_W-1:0]  reference,
  output logic [POS_W-1:0]  neighbor,
  output logic [ADDR_W-1:0] neighbor_idx,
  output logic              pair_valid,
  input  logic              pair_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CntW = ADDR_W + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  // Latched pass parameters
  logic [POS_W-1:0]  ref_q;
  logic [ADDR_W-1:0] ref_idx_q;
  logic              self_q;
  logic [CntW-1:0]   n_q;

  // Address walk; one bit wider than the address so N = 2^ADDR_W terminates
  logic [CntW-1:0]   addr_q, addr_d;

  // Read issued last cycle, data arrives this cycle
  logic              inflight_q;
  logic [ADDR_W-1:0] inflight_idx_q;

  // 2-entry output buffer: entry 0 is the head
  logic [POS_W-1:0]  e0_pos_q, e0_pos_d, e1_pos_q, e1_pos_d;
  logic [ADDR_W-1:0] e0_idx_q, e0_idx_d, e1_idx_q, e1_idx_d;
  logic [1:0]        count_q, count_d;

  logic              accept;
  logic [CntW-1:0]   eff_addr;
  logic              addr_left;
  logic [1:0]        occ;
  logic              rd_en;
  logic              push;
  logic              pop;

  // Step over the self-pair address without spending a cycle on it.
  function automatic logic [CntW-1:0] skip_adj(input logic [CntW-1:0]   a,
                                               input logic              skip_en,
                                               input logic [ADDR_W-1:0] ridx);
    return (skip_en && (a == {1'b0, ridx})) ? a + CntW'(1) : a;
  endfunction

  // Read issue: occupancy counts committed entries plus the read in flight,
  // so the buffer can never overflow whatever pair_ready does.
  always_comb begin
    accept    = (state_q == StIdle) && start;
    eff_addr  = skip_adj(addr_q, self_q, ref_idx_q);
    addr_left = eff_addr < n_q;
    occ       = count_q + 2'(inflight_q);
    rd_en     = (state_q == StRun) && addr_left && (occ < 2'd2);
    mem_rd_en = rd_en;
    mem_addr  = rd_en ? eff_addr[ADDR_W-1:0] : '0;
  end

  // Head of buffer; when empty, returning read data bypasses straight to the output.
  always_comb begin
    pair_valid   = (count_q != 2'd0) || inflight_q;
    neighbor     = '0;
    neighbor_idx = '0;
    if (count_q != 2'd0) begin
      neighbor     = e0_pos_q;
      neighbor_idx = e0_idx_q;
    end else if (inflight_q) begin
      neighbor     = mem_rd_data;
      neighbor_idx = inflight_idx_q;
    end
    push = inflight_q;
    pop  = pair_valid && pair_ready;
  end

  // Buffer next state
  always_comb begin
    e0_pos_d = e0_pos_q;
    e0_idx_d = e0_idx_q;
    e1_pos_d = e1_pos_q;
    e1_idx_d = e1_idx_q;
    count_d  = count_q + 2'(push) - 2'(pop);
    if (pop && (count_q == 2'd2)) begin
      e0_pos_d = e1_pos_q;
      e0_idx_d = e1_idx_q;
    end
    // Bypassed data consumed the same cycle is never stored.
    if (push && !(pop && (count_q == 2'd0))) begin
      if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
        e0_pos_d = mem_rd_data;
        e0_idx_d = inflight_idx_q;
      end else begin
        e1_pos_d = mem_rd_data;
        e1_idx_d = inflight_idx_q;
      end
    end
  end

  // FSM next state. RUN ends on the cycle of the last transfer so that done
  // follows it immediately.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d  = '0;
          state_d = (num_neighbors == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        addr_d = rd_en ? eff_addr + CntW'(1) : eff_addr;
        if ((skip_adj(addr_d, self_q, ref_idx_q) >= n_q) && !rd_en && (count_d == 2'd0)) begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      ref_q          <= '0;
      ref_idx_q      <= '0;
      self_q         <= 1'b0;
      n_q            <= '0;
      addr_q         <= '0;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
      e0_pos_q       <= '0;
      e0_idx_q       <= '0;
      e1_pos_q       <= '0;
      e1_idx_q       <= '0;
      count_q        <= 2'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      inflight_q <= rd_en;
      if (rd_en) begin
        inflight_idx_q <= eff_addr[ADDR_W-1:0];
      end
      e0_pos_q <= e0_pos_d;
      e0_idx_q <= e0_idx_d;
      e1_pos_q <= e1_pos_d;
      e1_idx_q <= e1_idx_d;
      count_q  <= count_d;
      if (accept) begin
        ref_q     <= ref_pos;
        ref_idx_q <= ref_idx;
        self_q    <= self_cell;
        n_q       <= num_neighbors;
      end
    end
  end

  assign reference = ref_q;
  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_lj_pair_feeder.sv
// Self-checking bench for lj_pair_feeder: directed and randomized passes against a
// model that lists the expected pair indices and checks handshake rules per cycle.
module tb_lj_pair_feeder;

  localparam int ADDR_W = 8;
  localparam int POS_W  = 96;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [POS_W-1:0]  ref_pos = '0;
  logic [ADDR_W-1:0] ref_idx = '0;
  logic              self_cell = 1'b0;
  logic [ADDR_W:0]   num_neighbors = '0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [POS_W-1:0]  mem_rd_data = '0;
  logic [POS_W-1:0]  reference;
  logic [POS_W-1:0]  neighbor;
  logic [ADDR_W-1:0] neighbor_idx;
  logic              pair_valid;
  logic              pair_ready = 1'b1;
  logic              busy;
  logic              done;

  lj_pair_feeder #(.ADDR_W(ADDR_W), .POS_W(POS_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ref_pos      (ref_pos),
    .ref_idx      (ref_idx),
    .self_cell    (self_cell),
    .num_neighbors(num_neighbors),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .reference    (reference),
    .neighbor     (neighbor),
    .neighbor_idx (neighbor_idx),
    .pair_valid   (pair_valid),
    .pair_ready   (pair_ready),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Neighbour-cell BRAM model, 1-cycle read latency
  logic [POS_W-1:0] mem [2**ADDR_W];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  int checks = 0;
  int errors = 0;
  bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_mem_rd_en"}, mem_rd_en, 0);
    chk({pfx, "_mem_addr"}, mem_addr, 0);
    chk({pfx, "_reference"}, reference, 0);
    chk({pfx, "_neighbor"}, neighbor, 0);
    chk({pfx, "_neighbor_idx"}, neighbor_idx, 0);
    chk({pfx, "_pair_valid"}, pair_valid, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
  endtask

  // mode: 0 = ready always high, 1 = fixed stall pattern, 2 = random ready.
  // repulse: pulse start again mid-pass with different parameters.
  task automatic run_pass(input int n, input bit self, input int ridx,
                          input logic [POS_W-1:0] rpos, input int mode, input bit repulse);
    int exp_all[$];
    int npairs, cyc, bound, last_xfer, first_valid, issued, xfers, pat_i, tmp;
    bit prev_stall, got_done;
    logic [POS_W-1:0]  prev_nb;
    logic [ADDR_W-1:0] prev_idx;

    for (int i = 0; i < n; i++) if (!(self && i == ridx)) exp_all.push_back(i);
    npairs = exp_all.size();
    bound = 30 * (n + 2) + 20;

    // Cycle 0: start accepted
    start = 1'b1;
    ref_pos = rpos;
    ref_idx = ridx[ADDR_W-1:0];
    self_cell = self;
    num_neighbors = n[ADDR_W:0];
    pair_ready = 1'b1;
    @(posedge clk); #1;

    cyc = 1; last_xfer = 0; first_valid = -1; issued = 0; xfers = 0; pat_i = 0;
    prev_stall = 0; got_done = 0; prev_nb = '0; prev_idx = '0;
    while (!got_done && cyc < bound) begin
      // Disturb the inputs after acceptance; the DUT must use its latched copies.
      tmp = n + 5;
      ref_pos = ~rpos;
      ref_idx = ADDR_W'(ridx + 1);
      self_cell = ~self;
      num_neighbors = tmp[ADDR_W:0];
      start = repulse && (cyc == 2 || cyc == 3);
      case (mode)
        0: pair_ready = 1'b1;
        1: begin pair_ready = pat[pat_i % 7]; pat_i++; end
        default: pair_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (cyc == 1) chk("busy_cycle1", busy, n != 0);
      if (prev_stall) begin
        chk("stall_valid", pair_valid, 1);
        chk("stall_neighbor", neighbor, prev_nb);
        chk("stall_idx", neighbor_idx, prev_idx);
      end
      if (mem_rd_en) begin
        chk("rd_occupancy", (issued - xfers) < 2, 1);
        chk("rd_addr", mem_addr, issued < npairs ? exp_all[issued] : 'h1ff);
        issued++;
      end
      if (pair_valid && first_valid < 0) first_valid = cyc;
      if (pair_valid && pair_ready) begin
        chk("xfer_idx", neighbor_idx, xfers < npairs ? exp_all[xfers] : 'h1ff);
        if (xfers < npairs) chk("xfer_neighbor", neighbor, mem[exp_all[xfers]]);
        chk("xfer_reference", reference, rpos);
        xfers++;
        last_xfer = cyc;
      end
      if (done) begin
        got_done = 1;
        chk("done_cycle", cyc, npairs == 0 ? 1 : last_xfer + 1);
        chk("done_busy", busy, 0);
        chk("done_valid", pair_valid, 0);
        chk("pair_count", xfers, npairs);
      end else begin
        chk("busy_during_pass", busy, 1);
      end
      prev_stall = pair_valid && !pair_ready;
      prev_nb = neighbor;
      prev_idx = neighbor_idx;
      @(posedge clk); #1;
      cyc++;
    end
    if (!got_done) chk("timeout_done", done, 1);
    start = 1'b0;
    #1;
    chk("done_single_pulse", done, 0);
    chk("idle_busy", busy, 0);
    chk("reference_held", reference, rpos);
    if (mode == 0 && npairs > 0) begin
      chk("first_valid_cycle", first_valid, 2);
      chk("contiguous_last_xfer", last_xfer, npairs + 1);
    end
  endtask

  initial begin
    logic [POS_W-1:0] rp;
    int n, ridx;
    bit self;

    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = {$urandom, $urandom, $urandom};
    mem[0] = {32'h40600000, 32'h400ccccd, 32'h4083d70a};
    mem[1] = {32'h40400000, 32'h3f8ccccd, 32'h4093d70a};
    mem[2] = {32'h40700000, 32'h401ccccd, 32'h40a3d70a};

    // Reset values
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic pass, no self-skip, ready high
    run_pass(3, 0, 0, {32'h41580000, 32'h40a66666, 32'h4151eb85}, 0, 0);
    // Self-skip in the middle and at address 0
    run_pass(3, 1, 1, {$urandom, $urandom, $urandom}, 0, 0);
    run_pass(4, 1, 0, {$urandom, $urandom, $urandom}, 0, 0);
    // Backpressure pattern
    run_pass(4, 0, 0, {$urandom, $urandom, $urandom}, 1, 0);
    // Empty cell
    run_pass(0, 0, 0, {$urandom, $urandom, $urandom}, 0, 0);

    // Reset mid-pass while a pair is valid and a read is in flight
    start = 1'b1;
    ref_pos = {$urandom, $urandom, $urandom};
    num_neighbors = 9'd8;
    self_cell = 1'b0;
    pair_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_valid", pair_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_outputs("midpass_reset");
    @(posedge clk); #1;
    chk("post_reset_valid", pair_valid, 0);
    chk("post_reset_busy", busy, 0);
    run_pass(2, 0, 0, {$urandom, $urandom, $urandom}, 0, 0);

    // start re-pulsed while busy
    run_pass(5, 0, 0, {$urandom, $urandom, $urandom}, 2, 1);

    // Full-size cell, last address is the self-pair
    run_pass(256, 1, 255, {$urandom, $urandom, $urandom}, 2, 0);

    // Randomized passes
    for (int k = 0; k < 12; k++) begin
      n = $urandom_range(1, 40);
      self = 1'($urandom_range(0, 1));
      ridx = $urandom_range(0, n - 1);
      if (n == 1) self = 0;
      rp = {$urandom, $urandom, $urandom};
      run_pass(n, self, ridx, rp, (k % 3 == 0) ? 0 : 2, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lj_pair_feeder.md
# lj_pair_feeder

Streams (reference, neighbour) particle-position pairs into the combinational LJ force unit. It latches one reference particle and walks a neighbour-cell position memory (synchronous BRAM, 1-cycle read latency). It skips the self-pair when the reference lies in the same cell. Each pair goes out on a valid/ready handshake, so the downstream force/accumulate pipeline can apply backpressure without losing or duplicating pairs.

## Interface
- ADDR_W, 8, neighbour-memory address width; max cell population 2^ADDR_W
- POS_W, 96, packed position width: x in [31:0], y in [63:32], z in [95:64], IEEE-754 FP32 each

- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  pulse; begins a pass; accepted only in IDLE
- ref_pos  in  POS_W  reference position; latched on accepted start
- ref_idx  in  ADDR_W  reference index within its cell; latched on start
- self_cell  in  1  1 = neighbour cell is the reference's own cell; enables self-skip; latched
- num_neighbors  in  ADDR_W+1  neighbour count N (0..2^ADDR_W); latched
- mem_rd_en  out  1  neighbour-memory read strobe
- mem_addr  out  ADDR_W  neighbour-memory read address
- mem_rd_data  in  POS_W  read data; valid the cycle after mem_rd_en
- reference  out  POS_W  latched ref_pos; feeds LJ reference input
- neighbor  out  POS_W  neighbour position; feeds LJ neighbor input
- neighbor_idx  out  ADDR_W  memory index of the current neighbour
- pair_valid  out  1  reference/neighbor/neighbor_idx valid
- pair_ready  in  1  downstream accepts; transfer = pair_valid & pair_ready
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  1-cycle pulse at end of pass

## Operation
- FSM states:
  - IDLE: start → RUN; latches ref_pos, ref_idx, self_cell, N; addr counter = 0.
  - RUN: issues reads and drains output; when all addresses are issued, nothing is in flight and the buffer is empty → DONE.
  - DONE: done=1 for one cycle → IDLE.
- N = 0: start → DONE directly; no reads, no pair_valid.
- Address walk: 0 .. N-1 in ascending order. When self_cell=1, address == ref_idx is skipped without a read and without a bubble; the counter advances past it in the same cycle.
- Output buffer: 2-entry FIFO (output register + skid register), each entry {position, index}.
- Read issue rule: mem_rd_en=1 only when occupied entries + reads in flight < 2 and addresses remain. This guarantees no overflow under any pair_ready pattern.
- Returned data is written into the buffer the cycle it arrives. Head of buffer drives neighbor/neighbor_idx/pair_valid.
- Ordering: pairs leave in ascending index order. No drops, no duplicates.
- While pair_valid=1 and pair_ready=0, neighbor, neighbor_idx and reference stay stable.
- reference holds the latched ref_pos for the whole pass. It keeps that value after done until the next accepted start.
- start while busy, or while in DONE: ignored.
- Counter width is ADDR_W+1, so N = 2^ADDR_W terminates correctly. mem_addr is the low ADDR_W bits.

## Timing
- Reset values: mem_rd_en=0, mem_addr=0, reference=0, neighbor=0, neighbor_idx=0, pair_valid=0, busy=0, done=0; FSM=IDLE; FIFO empty; in-flight cleared.
- Reset mid-pass: takes effect on the next edge regardless of state. In-flight read data arriving afterwards is discarded.
- start sampled at cycle 0:
  - busy=1 and first mem_rd_en (addr 0, or 1 if skipped) at cycle 1.
  - first pair_valid at cycle 2, the cycle data returns through the FIFO write path.
- Throughput with pair_ready held high: 1 pair/cycle, contiguous.
- done: pulses the cycle after the final transfer; busy drops in the same cycle done rises.
- N = 0: done at cycle 1; busy stays 0.

## Test plan
- N=3, self_cell=0, memory[0..2]={4083d70a,400ccccd,40600000}-style positions, ref_pos={4151eb85,40a66666,41580000}, pair_ready=1 → pair_valid cycles 2,3,4 with idx 0,1,2; reference constant; done at cycle 5.
- self_cell=1, ref_idx=1, N=3 → exactly two pairs, idx 0 then 2; address 1 never on mem_addr with mem_rd_en=1.
- N=4, pair_ready pattern 1,0,0,1,0,1,1,… → 4 transfers in order 0..3; outputs stable while stalled; mem_rd_en never raised with 2 entries committed.
- N=0 → done at cycle 1, no mem_rd_en, no pair_valid, busy stays 0.
- rst asserted mid-pass with pair_valid=1 → next cycle all outputs at reset values. A new start with N=2 then yields exactly idx 0,1.
- start re-pulsed while busy → ignored; pass completes with the original N and ref_pos; single done pulse.
